prog_loader: RTL and testbench
==============================

# prog_loader

Byte-serial program loader on the write side of the instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit words: byte at offset k lands in bits [8k+7:8k]. Issues one word write per assembled word at byte addresses 0, 4, 8, …, and holds the CPU while loading. Sits between the host/UART byte source and the instruction memory write port; the fetch side reads the same image back with the same byte order.

## Interface

- DEPTH_WORDS, 8: instruction memory capacity in 32-bit words (32 bytes).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request; honoured only in IDLE or ERR.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts byte_in this cycle; a byte transfers when byte_valid and byte_ready are both 1.
- wr_en  out  1  one-cycle word write strobe to the instruction memory.
- wr_addr  out  32  byte address of the write, always a multiple of 4.
- wr_data  out  32  assembled word, little-endian.
- cpu_hold  out  1  stalls the CPU/PC while a load is in progress.
- done  out  1  one-cycle pulse when the last word has been written.
- err  out  1  sticky length error flag.

## Operation

- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE:
  - byte_ready=0, cpu_hold=0.
  - start → LEN; clears err, word index and byte counter.
- LEN:
  - byte_ready=1, cpu_hold=1.
  - On transfer, byte_in is the word count N.
  - N==0 or N>DEPTH_WORDS → ERR.
  - Otherwise latch N and go to DATA with byte_cnt=0.
- DATA:
  - byte_ready=1, cpu_hold=1.
  - Each transfer writes byte_in into word_buf[8*byte_cnt+7 : 8*byte_cnt], then byte_cnt++ (2-bit, wraps).
  - Transfer with byte_cnt==3 → WRITE.
  - Cycles with byte_valid=0 hold all state.
- WRITE:
  - byte_ready=0, cpu_hold=1.
  - Drives wr_en=1, wr_addr={word_idx,2'b00} zero-extended, wr_data=word_buf.
  - Then word_idx++.
  - If word_idx==N-1 → DONE; else → DATA.
- DONE:
  - done=1, cpu_hold=1, byte_ready=0.
  - Next cycle → IDLE.
- ERR:
  - err=1, cpu_hold=0, byte_ready=0.
  - start → LEN (err clears on that edge).
  - Otherwise stays in ERR.
- start outside IDLE/ERR is ignored.
- No write is issued for a partially received word.
- Memory content beyond word N-1 is untouched.
- wr_addr and wr_data are don't-care when wr_en=0, but are held at their last values (no X).

## Timing

- Reset: state=IDLE; byte_ready, wr_en, cpu_hold, done, err = 0; wr_addr, wr_data, word_buf, word_idx, byte_cnt, N = 0.
- rst mid-load aborts immediately:
  - No further wr_en.
  - cpu_hold drops the cycle after the reset edge.
  - Words already written stay written.
- byte_ready is a registered function of state only; it does not depend on byte_valid (no combinational path from byte_valid to byte_ready).
- Latency:
  - start at edge t → byte_ready=1 from cycle t+1.
  - 4th byte of a word accepted at edge t → wr_en high during cycle t+1.
  - Last word: wr_en during cycle t+1, done during cycle t+2, IDLE (cpu_hold=0) from cycle t+3.
- Throughput: 5 cycles per word minimum; a full 8-word load is 1 + 8×5 + 1 = 42 cycles from the first accepted byte to done, with byte_valid held high.
- Exactly one wr_en pulse per word, never two consecutive wr_en cycles.

## Test plan

- Normal load with byte_valid held high:
  - Stimulus: start, then bytes 02, 13 00 00 00, 93 00 10 00.
  - Required: wr_en at addr 0 data 0x00000013, then addr 4 data 0x00100093; done one cycle after the second write; cpu_hold=0 afterwards.
- Backpressure gaps:
  - Stimulus: same stream with byte_valid toggling 1/0 every cycle.
  - Required: identical writes; no state change on idle cycles; exactly 2 wr_en pulses.
- Length errors:
  - N=00 → err=1, byte_ready=0, no wr_en, cpu_hold=0.
  - N=09 → same response.
  - Then start followed by N=01 and bytes AA BB CC DD → err clears, write 0xDDCCBBAA at addr 0.
- Full-capacity load:
  - Stimulus: N=08, bytes 00..1F.
  - Required: 8 writes at addr 0,4,…,28; word 7 = 0x1F1E1D1C; done 42 cycles after the first accepted byte.
- Reset mid-word:
  - Stimulus: rst after 2 of 4 bytes of word 1.
  - Required: no write for word 1; all outputs at reset values next cycle; a fresh load afterwards works from addr 0.
- start during DATA:
  - Stimulus: assert start while in DATA.
  - Required: no effect; byte_cnt, word_idx and N unchanged.

Source files
------------

// File: rtl/prog_loader_if.sv
// ============================================================================
// Module   : prog_loader_if
// Brief    : Byte-stream and instruction-memory write bundle for prog_loader.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface prog_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module   : prog_loader
// Brief    : Length-prefixed byte-serial loader writing little-endian words
//            into instruction memory while holding the CPU.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module prog_loader #(
  parameter int DEPTH_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS + 1);
  localparam logic [7:0] c_depth = 8'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           r_state;
  logic [1:0]       r_byte_cnt;
  logic [IDX_W-1:0] r_word_idx;
  logic [7:0]       r_n;
  logic [31:0]      r_word_buf;

  logic             r_byte_ready;
  logic             r_wr_en;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_cpu_hold;
  logic             r_done;
  logic             r_err;

  logic             w_xfer;
  logic             w_len_bad;
  logic             w_last_word;
  logic [31:0]      w_merged;

  assign w_xfer      = bus.byte_valid & r_byte_ready;
  assign w_len_bad   = (bus.byte_in == 8'd0) || (bus.byte_in > c_depth);
  assign w_last_word = (8'(r_word_idx) == (r_n - 8'd1));

  // Word buffer with the incoming byte dropped into its little-endian lane,
  // so the fourth byte can go straight to wr_data on the same edge.
  always_comb begin
    w_merged = r_word_buf;
    w_merged[{r_byte_cnt, 3'b000} +: 8] = bus.byte_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= 2'd0;
      r_word_idx   <= '0;
      r_n          <= 8'd0;
      r_word_buf   <= 32'd0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 32'd0;
      r_wr_data    <= 32'd0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE, S_ERR: begin
          if (bus.start) begin
            r_state      <= S_LEN;
            r_byte_ready <= 1'b1;
            r_cpu_hold   <= 1'b1;
            r_err        <= 1'b0;
            r_word_idx   <= '0;
            r_byte_cnt   <= 2'd0;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            if (w_len_bad) begin
              r_state      <= S_ERR;
              r_byte_ready <= 1'b0;
              r_cpu_hold   <= 1'b0;
              r_err        <= 1'b1;
            end else begin
              r_state    <= S_DATA;
              r_n        <= bus.byte_in;
              r_byte_cnt <= 2'd0;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word_buf <= w_merged;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state      <= S_WRITE;
              r_byte_ready <= 1'b0;
              r_wr_en      <= 1'b1;
              r_wr_addr    <= 32'({r_word_idx, 2'b00});
              r_wr_data    <= w_merged;
            end
          end
        end
        S_WRITE: begin
          r_word_idx <= r_word_idx + IDX_W'(1);
          if (w_last_word) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state      <= S_DATA;
            r_byte_ready <= 1'b1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_cpu_hold <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b0;
          r_cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.cpu_hold   = r_cpu_hold;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Table-driven, scoreboarded bench for prog_loader.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prog_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_if bus();

  prog_loader #(.DEPTH_WORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]   n;
    logic [255:0] bytes;
    int           nbytes;
    bit           gaps;
    bit           exp_err;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_wlast;
    int           exp_span;
    int           start_at;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  wr_t         sb_q[$];
  int          wr_count = 0;
  int          done_seen = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;
  logic [31:0] first_data = 32'd0;
  logic [31:0] last_data = 32'd0;
  bit          prev_wr = 1'b0;
  logic [31:0] mdl_buf = 32'd0;
  logic [31:0] mdl_addr = 32'd0;
  int          mdl_k = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.wr_en === 1'b1) begin
      check("wr_en_spacing", 32'(prev_wr), 32'd0);
      check("write_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("wr_addr", bus.wr_addr, e.addr);
        check("wr_data", bus.wr_data, e.data);
      end
      wr_count++;
      last_wr_cyc = cyc;
      if (wr_count == 1) first_data = bus.wr_data;
      last_data = bus.wr_data;
    end
    if (bus.done === 1'b1) begin
      done_seen++;
      done_cyc = cyc;
    end
    prev_wr = (bus.wr_en === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb_q.delete();
    wr_count   = 0;
    done_seen  = 0;
    mdl_buf    = 32'd0;
    mdl_addr   = 32'd0;
    mdl_k      = 0;
    first_data = 32'd0;
    last_data  = 32'd0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, output int xfer_cyc);
    bit rdy;
    rdy = 1'b0;
    xfer_cyc = -1;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 64 && !rdy; i++) begin
      @(negedge clk);
      rdy = (bus.byte_ready === 1'b1);
      xfer_cyc = cyc;
      tick();
    end
    bus.byte_valid = 1'b0;
    check("byte_accept", 32'(rdy), 32'd1);
    if (gap) tick();
  endtask

  // Reference assembly: byte k of each group of four goes to bits [8k+7:8k].
  task automatic data_byte(input logic [7:0] b, input bit gap);
    int c;
    send_byte(b, 1'b0, c);
    mdl_buf[8*mdl_k +: 8] = b;
    mdl_k++;
    if (mdl_k == 4) begin
      sb_q.push_back({mdl_addr, mdl_buf});
      mdl_addr += 32'd4;
      mdl_k = 0;
    end
    if (gap) tick();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && done_seen == 0; i++) tick();
    check("done_seen", 32'(done_seen), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_wr_addr", bus.wr_addr, 32'd0);
    check("rst_wr_data", bus.wr_data, 32'd0);
  endtask

  task automatic run_load(input vec_t v);
    int len_cyc;
    clear_model();
    pulse_start();
    check("ready_after_start", 32'(bus.byte_ready), 32'd1);
    check("hold_after_start", 32'(bus.cpu_hold), 32'd1);
    check("err_cleared", 32'(bus.err), 32'd0);
    send_byte(v.n, v.gaps, len_cyc);
    if (v.exp_err) begin
      check("len_err", 32'(bus.err), 32'd1);
      check("len_err_ready", 32'(bus.byte_ready), 32'd0);
      check("len_err_hold", 32'(bus.cpu_hold), 32'd0);
      repeat (3) tick();
      check("len_err_sticky", 32'(bus.err), 32'd1);
      check("len_err_no_write", 32'(wr_count), 32'd0);
    end else begin
      for (int i = 0; i < v.nbytes; i++) begin
        if (i == v.start_at) begin
          pulse_start();
          check("ignored_start_ready", 32'(bus.byte_ready), 32'd1);
          check("ignored_start_hold", 32'(bus.cpu_hold), 32'd1);
        end
        data_byte(v.bytes[8*i +: 8], v.gaps);
      end
      wait_done();
      check("hold_released", 32'(bus.cpu_hold), 32'd0);
      check("wr_count", 32'(wr_count), 32'(v.n));
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("done_after_last_wr", 32'(done_cyc - last_wr_cyc), 32'd1);
      check("first_word", first_data, v.exp_w0);
      check("last_word", last_data, v.exp_wlast);
      if (v.exp_span != 0) check("load_span", 32'(done_cyc - len_cyc + 1), 32'(v.exp_span));
    end
  endtask

  function automatic vec_t mk(input logic [7:0] n, input logic [255:0] b, input int nb,
                              input bit g, input bit e, input logic [31:0] w0,
                              input logic [31:0] wl, input int span, input int sa);
    vec_t v;
    v.n = n; v.bytes = b; v.nbytes = nb; v.gaps = g; v.exp_err = e;
    v.exp_w0 = w0; v.exp_wlast = wl; v.exp_span = span; v.start_at = sa;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[7];
    logic [255:0] ramp;
    logic [255:0] two_words;
    logic [47:0]  partial;
    int           c;

    bus.start = 1'b0;
    bus.byte_in = 8'd0;
    bus.byte_valid = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 32; i++) ramp[8*i +: 8] = 8'(i);
    two_words = 256'h0010_0093_0000_0013;
    partial   = 48'h6655_4433_2211;

    vecs[0] = mk(8'd2, two_words, 8, 1'b0, 1'b0, 32'h0000_0013, 32'h0010_0093, 12, -1);
    vecs[1] = mk(8'd2, two_words, 8, 1'b1, 1'b0, 32'h0000_0013, 32'h0010_0093, 0, -1);
    vecs[2] = mk(8'd0, 256'd0, 0, 1'b0, 1'b1, 32'd0, 32'd0, 0, -1);
    vecs[3] = mk(8'd9, 256'd0, 0, 1'b0, 1'b1, 32'd0, 32'd0, 0, -1);
    vecs[4] = mk(8'd1, 256'hDDCC_BBAA, 4, 1'b0, 1'b0, 32'hDDCC_BBAA, 32'hDDCC_BBAA, 7, -1);
    vecs[5] = mk(8'd8, ramp, 32, 1'b0, 1'b0, 32'h0302_0100, 32'h1F1E_1D1C, 42, -1);
    vecs[6] = mk(8'd2, two_words, 8, 1'b0, 1'b0, 32'h0000_0013, 32'h0010_0093, 0, 6);

    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(bus.byte_ready), 32'd0);

    for (int k = 0; k < 7; k++) run_load(vecs[k]);

    // Reset two bytes into the second word: only the first word may land.
    clear_model();
    pulse_start();
    send_byte(8'd2, 1'b0, c);
    for (int i = 0; i < 6; i++) data_byte(partial[8*i +: 8], 1'b0);
    check("midload_hold", 32'(bus.cpu_hold), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs();
    rst = 1'b0;
    repeat (4) tick();
    check("midrst_wr_count", 32'(wr_count), 32'd1);
    check("midrst_word0", last_data, 32'h4433_2211);

    run_load(vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
